// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle accumulator machine: controller state
// codes, opcodes, ALU function codes and datapath mux selects.
package mc_ctrl_pkg;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_EXEC   = 4'd4;
    localparam logic [3:0] S_LOAD   = 4'd5;
    localparam logic [3:0] S_STORE  = 4'd6;
    localparam logic [3:0] S_JUMP   = 4'd7;
    localparam logic [3:0] S_BRZ    = 4'd8;
    localparam logic [3:0] S_HALT   = 4'd9;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_HLT = 3'b011;
    localparam logic [2:0] OP_LDA = 3'b100;
    localparam logic [2:0] OP_STA = 3'b101;
    localparam logic [2:0] OP_JMP = 3'b110;
    localparam logic [2:0] OP_JZ  = 3'b111;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_AND    = 2'b10;
    localparam logic [1:0] ALU_PASS_A = 2'b11;

    localparam logic IORD_PC     = 1'b0;
    localparam logic IORD_IR     = 1'b1;
    localparam logic SRCA_PC     = 1'b0;
    localparam logic SRCA_ACC    = 1'b1;
    localparam logic SRCB_MDR    = 1'b0;
    localparam logic SRCB_ONE    = 1'b1;
    localparam logic PCSRC_ALU   = 1'b0;
    localparam logic PCSRC_IR    = 1'b1;
    localparam logic TOREG_ALU   = 1'b0;
    localparam logic TOREG_MDR   = 1'b1;

endpackage

// File: rtl/mc_control_unit_wait.sv
// Memory wait-state counter: counts cycles of the current access and flags
// the final cycle (count == MEM_WAIT).
module mc_wait_counter
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    output logic       done,
    output logic [3:0] count
);

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

    // Cycle counter, cleared between accesses so each access starts at zero.
    always_ff @(posedge clk) begin
        if (!rst)
            count <= 4'd0;
        else if (clr)
            count <= 4'd0;
        else if (en)
            count <= count + 4'd1;
    end

    assign done = (count == WAIT_LAST);

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle Moore controller for the 16-bit accumulator datapath.
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | read instruction at PC; last cycle loads IR and bumps PC
// DECODE | one-cycle opcode dispatch, no strobes
// MEMRD  | read operand at IR[12:0] into MDR
// EXEC   | ACC <= ACC op MDR
// LOAD   | ACC <= MDR
// STORE  | write ACC to IR[12:0]
// JUMP   | PC <= IR
// BRZ    | PC <= IR when ACC is zero
// HALT   | parked until reset
module mc_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 0,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       opcode,
    output logic             PCWriteCond,
    output logic             PCWrite,
    output logic             IorD,
    output logic             memRead,
    output logic             memWrite,
    output logic             IRWrite,
    output logic             memToReg,
    output logic             accWrite,
    output logic             ALUSrcA,
    output logic             ALUSrcB,
    output logic             PCSrc,
    output logic [1:0]       ALUFunc,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    logic [3:0] state;
    logic [3:0] state_next;
    logic [2:0] op_q;
    logic       in_access;
    logic       wait_done;
    logic [3:0] wait_count;
    logic       retire;

    // Counter runs only inside memory-access states and restarts after each
    // final cycle, so every entry into FETCH/MEMRD/STORE begins at zero.
    assign in_access = (state == S_FETCH) || (state == S_MEMRD) || (state == S_STORE);

    mc_wait_counter #(.MEM_WAIT(MEM_WAIT)) u_wait (
        .clk   (clk),
        .rst   (rst),
        .clr   (!in_access || wait_done),
        .en    (1'b1),
        .done  (wait_done),
        .count (wait_count)
    );

    // Next-state selection.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (start) state_next = S_FETCH;
            S_FETCH:  if (wait_done) state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_STA:  state_next = S_STORE;
                    OP_JMP:  state_next = S_JUMP;
                    OP_JZ:   state_next = S_BRZ;
                    OP_HLT:  state_next = S_HALT;
                    default: state_next = S_MEMRD;
                endcase
            end
            S_MEMRD:  if (wait_done) state_next = (op_q == OP_LDA) ? S_LOAD : S_EXEC;
            S_EXEC:   state_next = S_FETCH;
            S_LOAD:   state_next = S_FETCH;
            S_STORE:  if (wait_done) state_next = S_FETCH;
            S_JUMP:   state_next = S_FETCH;
            S_BRZ:    state_next = S_FETCH;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_IDLE;
        endcase
    end

    // State register; the opcode is latched at DECODE so that the EXEC ALU
    // function comes from a register rather than straight from the IR bus.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
            op_q  <= 3'd0;
        end else begin
            state <= state_next;
            if (state == S_DECODE)
                op_q <= opcode;
        end
    end

    assign retire = (state == S_EXEC) || (state == S_LOAD) || (state == S_JUMP) ||
                    (state == S_BRZ) || ((state == S_STORE) && wait_done) ||
                    ((state == S_DECODE) && (opcode == OP_HLT));

    // Retired-instruction counter, wraps silently.
    always_ff @(posedge clk) begin
        if (!rst)
            instr_count <= '0;
        else if (retire)
            instr_count <= instr_count + 1'b1;
    end

    // Moore output decode from registered state and wait counter.
    always_comb begin
        PCWriteCond = 1'b0;
        PCWrite     = 1'b0;
        IorD        = IORD_PC;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        IRWrite     = 1'b0;
        memToReg    = TOREG_ALU;
        accWrite    = 1'b0;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_MDR;
        PCSrc       = PCSRC_ALU;
        ALUFunc     = ALU_ADD;
        halted      = 1'b0;
        case (state)
            S_FETCH: begin
                IorD    = IORD_PC;
                memRead = 1'b1;
                if (wait_done) begin
                    IRWrite = 1'b1;
                    ALUSrcA = SRCA_PC;
                    ALUSrcB = SRCB_ONE;
                    ALUFunc = ALU_ADD;
                    PCSrc   = PCSRC_ALU;
                    PCWrite = 1'b1;
                end
            end
            S_MEMRD: begin
                IorD    = IORD_IR;
                memRead = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA  = SRCA_ACC;
                ALUSrcB  = SRCB_MDR;
                ALUFunc  = op_q[1:0];
                memToReg = TOREG_ALU;
                accWrite = 1'b1;
            end
            S_LOAD: begin
                memToReg = TOREG_MDR;
                accWrite = 1'b1;
            end
            S_STORE: begin
                IorD     = IORD_IR;
                memWrite = 1'b1;
            end
            S_JUMP: begin
                PCSrc   = PCSRC_IR;
                PCWrite = 1'b1;
            end
            S_BRZ: begin
                ALUSrcA     = SRCA_ACC;
                ALUFunc     = ALU_PASS_A;
                PCSrc       = PCSRC_IR;
                PCWriteCond = 1'b1;
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench: three controller instances (W=0, W=2, W=0 with a 4-bit
// counter), each driven through hand-computed cycle sequences.
module tb_mc_control_unit;

    // Packed control vector, bit 13 down to 0:
    // PCWriteCond PCWrite IorD memRead memWrite IRWrite memToReg accWrite
    // ALUSrcA ALUSrcB PCSrc ALUFunc[1:0] halted
    localparam logic [13:0] E_NONE   = 14'h0000;
    localparam logic [13:0] E_FWAIT  = 14'h0400;
    localparam logic [13:0] E_FLAST  = 14'h1510;
    localparam logic [13:0] E_MEMRD  = 14'h0C00;
    localparam logic [13:0] E_EXSUB  = 14'h0062;
    localparam logic [13:0] E_LOAD   = 14'h00C0;
    localparam logic [13:0] E_STORE  = 14'h0A00;
    localparam logic [13:0] E_JUMP   = 14'h1008;
    localparam logic [13:0] E_BRZ    = 14'h202E;
    localparam logic [13:0] E_HALT   = 14'h0001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic        rst_a, start_a, rst_b, start_b, rst_c, start_c;
    logic [2:0]  op_a, op_b, op_c;
    logic [13:0] ctl_a, ctl_b, ctl_c;
    logic [15:0] cnt_a, cnt_b;
    logic [3:0]  cnt_c;

    mc_control_unit #(.MEM_WAIT(0), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst_a), .start(start_a), .opcode(op_a),
        .PCWriteCond(ctl_a[13]), .PCWrite(ctl_a[12]), .IorD(ctl_a[11]),
        .memRead(ctl_a[10]), .memWrite(ctl_a[9]), .IRWrite(ctl_a[8]),
        .memToReg(ctl_a[7]), .accWrite(ctl_a[6]), .ALUSrcA(ctl_a[5]),
        .ALUSrcB(ctl_a[4]), .PCSrc(ctl_a[3]), .ALUFunc(ctl_a[2:1]),
        .halted(ctl_a[0]), .instr_count(cnt_a)
    );

    mc_control_unit #(.MEM_WAIT(2), .CNT_W(16)) u_b (
        .clk(clk), .rst(rst_b), .start(start_b), .opcode(op_b),
        .PCWriteCond(ctl_b[13]), .PCWrite(ctl_b[12]), .IorD(ctl_b[11]),
        .memRead(ctl_b[10]), .memWrite(ctl_b[9]), .IRWrite(ctl_b[8]),
        .memToReg(ctl_b[7]), .accWrite(ctl_b[6]), .ALUSrcA(ctl_b[5]),
        .ALUSrcB(ctl_b[4]), .PCSrc(ctl_b[3]), .ALUFunc(ctl_b[2:1]),
        .halted(ctl_b[0]), .instr_count(cnt_b)
    );

    mc_control_unit #(.MEM_WAIT(0), .CNT_W(4)) u_c (
        .clk(clk), .rst(rst_c), .start(start_c), .opcode(op_c),
        .PCWriteCond(ctl_c[13]), .PCWrite(ctl_c[12]), .IorD(ctl_c[11]),
        .memRead(ctl_c[10]), .memWrite(ctl_c[9]), .IRWrite(ctl_c[8]),
        .memToReg(ctl_c[7]), .accWrite(ctl_c[6]), .ALUSrcA(ctl_c[5]),
        .ALUSrcB(ctl_c[4]), .PCSrc(ctl_c[3]), .ALUFunc(ctl_c[2:1]),
        .halted(ctl_c[0]), .instr_count(cnt_c)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then settle past the edge before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_a = 1'b0; start_a = 1'b0; op_a = 3'b000;
        rst_b = 1'b0; start_b = 1'b0; op_b = 3'b000;
        rst_c = 1'b0; start_c = 1'b0; op_c = 3'b000;
        step(); step();
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        chk("reset_ctl_a", {2'b0, ctl_a}, 16'h0);
        chk("reset_cnt_a", cnt_a, 16'h0);
        chk("reset_ctl_b", {2'b0, ctl_b}, 16'h0);
        chk("reset_ctl_c", {2'b0, ctl_c}, 16'h0);
        step();
        chk("idle_no_start_a", {2'b0, ctl_a}, 16'h0);

        // W=0: LDA
        op_a = 3'b100; start_a = 1'b1;
        step(); start_a = 1'b0;
        chk("lda_fetch", {2'b0, ctl_a}, {2'b0, E_FLAST});
        step(); chk("lda_decode", {2'b0, ctl_a}, {2'b0, E_NONE});
        step(); chk("lda_memrd", {2'b0, ctl_a}, {2'b0, E_MEMRD});
        step(); chk("lda_load", {2'b0, ctl_a}, {2'b0, E_LOAD});
        chk("lda_cnt_before", cnt_a, 16'd0);
        step(); chk("lda_next_fetch", {2'b0, ctl_a}, {2'b0, E_FLAST});
        chk("lda_cnt", cnt_a, 16'd1);

        // W=0: JZ
        op_a = 3'b111;
        step(); chk("jz_decode", {2'b0, ctl_a}, {2'b0, E_NONE});
        step(); chk("jz_brz", {2'b0, ctl_a}, {2'b0, E_BRZ});
        step(); chk("jz_next_fetch", {2'b0, ctl_a}, {2'b0, E_FLAST});
        chk("jz_cnt", cnt_a, 16'd2);

        // W=0: HLT, then start pulses must be ignored
        op_a = 3'b011;
        step(); chk("hlt_decode", {2'b0, ctl_a}, {2'b0, E_NONE});
        step(); chk("hlt_halted", {2'b0, ctl_a}, {2'b0, E_HALT});
        chk("hlt_cnt", cnt_a, 16'd3);
        for (int i = 0; i < 50; i++) begin
            start_a = i[0];
            op_a    = 3'(i);
            step();
            chk("hlt_hold", {2'b0, ctl_a}, {2'b0, E_HALT});
            chk("hlt_cnt_frozen", cnt_a, 16'd3);
        end
        start_a = 1'b0;
        rst_a = 1'b0;
        step(); rst_a = 1'b1;
        chk("hlt_reset_ctl", {2'b0, ctl_a}, 16'h0);
        chk("hlt_reset_cnt", cnt_a, 16'd0);
        step(); chk("hlt_reset_idle", {2'b0, ctl_a}, 16'h0);

        // W=2: SUB, 8 cycles
        op_b = 3'b001; start_b = 1'b1;
        step(); start_b = 1'b0;
        chk("sub_fetch0", {2'b0, ctl_b}, {2'b0, E_FWAIT});
        step(); chk("sub_fetch1", {2'b0, ctl_b}, {2'b0, E_FWAIT});
        step(); chk("sub_fetch2", {2'b0, ctl_b}, {2'b0, E_FLAST});
        step(); chk("sub_decode", {2'b0, ctl_b}, {2'b0, E_NONE});
        step(); chk("sub_memrd0", {2'b0, ctl_b}, {2'b0, E_MEMRD});
        step(); chk("sub_memrd1", {2'b0, ctl_b}, {2'b0, E_MEMRD});
        step(); chk("sub_memrd2", {2'b0, ctl_b}, {2'b0, E_MEMRD});
        step(); chk("sub_exec", {2'b0, ctl_b}, {2'b0, E_EXSUB});
        step(); chk("sub_next_fetch", {2'b0, ctl_b}, {2'b0, E_FWAIT});
        chk("sub_cnt", cnt_b, 16'd1);

        // W=2: STA, reset on second STORE cycle
        op_b = 3'b101;
        step(); chk("sta_fetch1", {2'b0, ctl_b}, {2'b0, E_FWAIT});
        step(); chk("sta_fetch2", {2'b0, ctl_b}, {2'b0, E_FLAST});
        step(); chk("sta_decode", {2'b0, ctl_b}, {2'b0, E_NONE});
        step(); chk("sta_store0", {2'b0, ctl_b}, {2'b0, E_STORE});
        step(); chk("sta_store1", {2'b0, ctl_b}, {2'b0, E_STORE});
        chk("sta_cnt_mid", cnt_b, 16'd1);
        rst_b = 1'b0;
        step(); rst_b = 1'b1;
        chk("sta_abort_ctl", {2'b0, ctl_b}, 16'h0);
        chk("sta_abort_cnt", cnt_b, 16'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("sta_abort_idle", {2'b0, ctl_b}, 16'h0);
        end

        // W=0, 4-bit counter: 16 JMPs wrap the count
        op_c = 3'b110; start_c = 1'b1;
        step(); start_c = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("jmp_fetch", {2'b0, ctl_c}, {2'b0, E_FLAST});
            chk("jmp_cnt", {12'b0, cnt_c}, {12'b0, 4'(i)});
            step(); chk("jmp_decode", {2'b0, ctl_c}, {2'b0, E_NONE});
            step(); chk("jmp_jump", {2'b0, ctl_c}, {2'b0, E_JUMP});
            step();
        end
        chk("jmp_wrap_fetch", {2'b0, ctl_c}, {2'b0, E_FLAST});
        chk("jmp_wrap_cnt", {12'b0, cnt_c}, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
